// File: rtl/ovi_vpu_exec.sv
// Vector-side stand-in for OVI bring-up: buffers issued instructions, executes them
// one at a time with a vl/sew-derived latency, and returns completion plus credit.
module ovi_vpu_exec #(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned OPND_W     = 64,
    parameter int unsigned VL_W       = 15,
    parameter int unsigned SEW_W      = 3,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LANE_BYTES = 8,
    parameter int unsigned PIPE_LAT   = 2,
    parameter int unsigned VLMAX      = 256
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ISSUE_VALID,
    input  logic [INSTR_W-1:0] ISSUE_INSTR,
    input  logic [OPND_W-1:0]  ISSUE_OPND,
    input  logic [VL_W-1:0]    ISSUE_VL,
    input  logic [SEW_W-1:0]   ISSUE_SEW,
    output logic               ISSUE_CREDIT,
    output logic               COMPLETED_VALID,
    output logic [INSTR_W-1:0] COMPLETED_INSTR,
    output logic [4:0]         COMPLETED_DEST,
    output logic               COMPLETED_ILLEGAL,
    output logic               BUSY,
    output logic               OVERFLOW
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BYTES_W = VL_W + 4;
    localparam int unsigned LAT_W   = BYTES_W + 2;
    localparam int unsigned LANE_SH = $clog2(LANE_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

    state_e state_q, state_d;

    logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
    logic [OPND_W-1:0]  fifo_opnd_q  [DEPTH];
    logic [VL_W-1:0]    fifo_vl_q    [DEPTH];
    logic [SEW_W-1:0]   fifo_sew_q   [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LAT_W-1:0]   cnt_q;
    logic [INSTR_W-1:0] cur_instr_q;
    logic [OPND_W-1:0]  cur_opnd_q;
    logic               cur_illegal_q;
    logic               push, pop;

    logic [BYTES_W-1:0] head_bytes, head_beats;
    logic [LAT_W-1:0]   head_lat;
    logic               head_illegal;

    logic               valid_q, valid_d;
    logic               credit_q, credit_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [4:0]         dest_q, dest_d;
    logic               illegal_q, illegal_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;

    // The operand is carried with the entry but has no effect on timing.
    logic               unused_opnd;
    assign unused_opnd = ^cur_opnd_q;

    // Execute latency of the FIFO head; illegal instructions take a single beat.
    always_comb begin
        head_illegal = (fifo_sew_q[rd_ptr_q] > SEW_W'(3)) ||
                       (fifo_vl_q[rd_ptr_q] > VL_W'(VLMAX));
        head_bytes   = BYTES_W'(fifo_vl_q[rd_ptr_q]) << fifo_sew_q[rd_ptr_q][1:0];
        head_beats   = (head_bytes + BYTES_W'(LANE_BYTES - 1)) >> LANE_SH;
        if (head_beats == '0) begin
            head_beats = BYTES_W'(1);
        end
        head_lat = head_illegal ? LAT_W'(1) : LAT_W'(head_beats) + LAT_W'(PIPE_LAT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, FIFO pop/push decisions and occupancy.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        push    = ISSUE_VALID && ((count_q < CNT_W'(DEPTH)) || pop);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Output values for the coming cycle, registered below.
    always_comb begin
        valid_d    = (state_d == ST_DONE);
        credit_d   = (state_d == ST_DONE);
        instr_d    = '0;
        dest_d     = '0;
        illegal_d  = 1'b0;
        if (state_d == ST_DONE) begin
            instr_d   = cur_instr_q;
            dest_d    = cur_instr_q[11:7];
            illegal_d = cur_illegal_q;
        end
        busy_d     = (count_d != '0) || (state_d != ST_IDLE);
        overflow_d = overflow_q || (ISSUE_VALID && !push);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= ISSUE_INSTR;
            fifo_opnd_q[wr_ptr_q]  <= ISSUE_OPND;
            fifo_vl_q[wr_ptr_q]    <= ISSUE_VL;
            fifo_sew_q[wr_ptr_q]   <= ISSUE_SEW;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            cur_instr_q   <= '0;
            cur_opnd_q    <= '0;
            cur_illegal_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
                cur_instr_q   <= fifo_instr_q[rd_ptr_q];
                cur_opnd_q    <= fifo_opnd_q[rd_ptr_q];
                cur_illegal_q <= head_illegal;
                cnt_q         <= head_lat - LAT_W'(1);
            end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q    <= 1'b0;
            credit_q   <= 1'b0;
            instr_q    <= '0;
            dest_q     <= '0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            credit_q   <= credit_d;
            instr_q    <= instr_d;
            dest_q     <= dest_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign COMPLETED_VALID   = valid_q;
    assign ISSUE_CREDIT      = credit_q;
    assign COMPLETED_INSTR   = instr_q;
    assign COMPLETED_DEST    = dest_q;
    assign COMPLETED_ILLEGAL = illegal_q;
    assign BUSY              = busy_q;
    assign OVERFLOW          = overflow_q;

endmodule

// File: tb/tb_ovi_vpu_exec.sv
// Scoreboard bench for ovi_vpu_exec: expected completions (fields and cycle) are
// queued at issue time from a timing model and checked when the DUT completes.
module tb_ovi_vpu_exec;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ISSUE_VALID = 1'b0;
    logic [31:0] ISSUE_INSTR = '0;
    logic [63:0] ISSUE_OPND = '0;
    logic [14:0] ISSUE_VL = '0;
    logic [2:0]  ISSUE_SEW = '0;
    logic        ISSUE_CREDIT, COMPLETED_VALID, COMPLETED_ILLEGAL, BUSY, OVERFLOW;
    logic [31:0] COMPLETED_INSTR;
    logic [4:0]  COMPLETED_DEST;

    ovi_vpu_exec dut (
        .CLK(CLK), .RST(RST),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR), .ISSUE_OPND(ISSUE_OPND),
        .ISSUE_VL(ISSUE_VL), .ISSUE_SEW(ISSUE_SEW), .ISSUE_CREDIT(ISSUE_CREDIT),
        .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_INSTR(COMPLETED_INSTR),
        .COMPLETED_DEST(COMPLETED_DEST), .COMPLETED_ILLEGAL(COMPLETED_ILLEGAL),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        int          done;
    } exp_t;

    exp_t sb[$];
    int   pop_edges[$];
    int   last_done = 0;
    int   errors = 0;
    int   checks = 0;
    int   credits = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int calc_lat(input int vl, input int sew);
        int bytes, beats;
        if (sew > 3 || vl > 256) return 1;
        bytes = vl << sew;
        beats = (bytes + 7) / 8;
        if (beats == 0) beats = 1;
        return beats + 2;
    endfunction

    // Drive one issue at a negedge; it is sampled at the next rising edge.
    task automatic issue(input int vl, input int sew, output int exp_done);
        int   e, occ, pe;
        exp_t x;
        e   = cyc + 1;
        occ = 0;
        foreach (pop_edges[i]) if (pop_edges[i] > e) occ++;
        exp_done = -1;
        ISSUE_INSTR = $urandom;
        ISSUE_OPND  = {$urandom, $urandom};
        ISSUE_VL    = 15'(vl);
        ISSUE_SEW   = 3'(sew);
        ISSUE_VALID = 1'b1;
        if (occ < 4) begin
            pe       = ((e > last_done) ? e : last_done) + 1;
            exp_done = pe + calc_lat(vl, sew);
            last_done = exp_done;
            pop_edges.push_back(pe);
            x.instr = ISSUE_INSTR;
            x.ill   = (sew > 3 || vl > 256);
            x.done  = exp_done;
            sb.push_back(x);
        end
        @(negedge CLK);
        ISSUE_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        sb.delete();
        pop_edges.delete();
        last_done = 0;
        check("rst_busy", 64'(BUSY), 0);
        check("rst_overflow", 64'(OVERFLOW), 0);
        check("rst_valid", 64'(COMPLETED_VALID), 0);
        check("rst_credit", 64'(ISSUE_CREDIT), 0);
        RST = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || BUSY) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 1, 0);
        @(negedge CLK);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Completion monitor: every DONE must match the head of the scoreboard.
    always @(negedge CLK) begin
        exp_t x;
        if (!RST) begin
            check("credit_eq_valid", 64'(ISSUE_CREDIT), 64'(COMPLETED_VALID));
            if (ISSUE_CREDIT) credits++;
            if (COMPLETED_VALID) begin
                if (sb.size() == 0) begin
                    check("stray_done", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("done_instr", 64'(COMPLETED_INSTR), 64'(x.instr));
                    check("done_dest", 64'(COMPLETED_DEST), 64'(x.instr[11:7]));
                    check("done_illegal", 64'(COMPLETED_ILLEGAL), 64'(x.ill));
                    check("done_cycle", 64'(cyc), 64'(x.done));
                end
            end else begin
                check("idle_fields", {26'b0, COMPLETED_INSTR, COMPLETED_DEST, COMPLETED_ILLEGAL}, 0);
            end
        end
    end

    initial begin
        int d, da, c0;
        repeat (3) @(negedge CLK);
        check("reset_valid", 64'(COMPLETED_VALID), 0);
        check("reset_credit", 64'(ISSUE_CREDIT), 0);
        check("reset_instr", 64'(COMPLETED_INSTR), 0);
        check("reset_busy", 64'(BUSY), 0);
        check("reset_overflow", 64'(OVERFLOW), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Single instruction, L=6; BUSY drops the cycle after DONE.
        c0 = credits;
        issue(8, 2, d);
        wait_until(d);
        check("t1_busy_at_done", 64'(BUSY), 1);
        @(negedge CLK);
        check("t1_busy_after", 64'(BUSY), 0);
        drain();
        check("t1_credits", 64'(credits - c0), 1);

        // Four back-to-back issues, L=3 each.
        c0 = credits;
        for (int i = 0; i < 4; i++) issue(8, 0, d);
        drain();
        check("t2_credits", 64'(credits - c0), 4);
        check("t2_overflow", 64'(OVERFLOW), 0);

        // Five issues while busy: the fifth is dropped.
        c0 = credits;
        issue(64, 3, d);
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 5; i++) issue(8, 0, d);
        check("t3_overflow_set", 64'(OVERFLOW), 1);
        drain();
        check("t3_credits", 64'(credits - c0), 5);
        check("t3_overflow_sticky", 64'(OVERFLOW), 1);

        // Reset mid-execution with two entries queued.
        issue(256, 3, d);
        issue(8, 0, d);
        issue(8, 0, d);
        repeat (6) @(negedge CLK);
        c0 = credits;
        do_reset();
        repeat (300) @(negedge CLK);
        check("t5_no_credit", 64'(credits - c0), 0);
        issue(8, 2, d);
        drain();
        check("t5_fresh_credit", 64'(credits - c0), 1);

        // Push onto a full FIFO on the same edge as a pop is accepted.
        c0 = credits;
        issue(64, 3, da);
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) issue(8, 0, d);
        wait_until(da);
        issue(8, 1, d);
        drain();
        check("t3v_overflow", 64'(OVERFLOW), 0);
        check("t3v_credits", 64'(credits - c0), 6);

        // Edge cases: vl=0 clamp, vl>VLMAX and sew>3 illegal.
        issue(0, 3, d);
        drain();
        issue(300, 2, d);
        drain();
        issue(8, 5, d);
        drain();

        // Wide latency: vl=256, sew=3 gives L=258.
        issue(256, 3, d);
        drain();
        check("t6_overflow", 64'(OVERFLOW), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
